// File: rtl/dram_pkg.sv
// Shared DRAM interface defaults, also consumed by the lenet datapath.
// Width and depth helpers live here so every user sizes the array the same way.
package dram_pkg;

    localparam int DRAM_DATA_WIDTH = 32;
    localparam int DRAM_ADDR_WIDTH = 18;
    localparam int DRAM_DEPTH      = 4096;
    localparam int DRAM_RD_LAT     = 2;
    localparam int PEND_WIDTH      = 4;

    function automatic int idxWidth(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/dram_rd_pipe.sv
// Read-latency shift register: each stage carries a valid bit, the read word
// and an out-of-range marker, so a request emerges exactly RD_LAT edges later.
module dram_rd_pipe
    import dram_pkg::*;
#(
    parameter int RD_LAT     = DRAM_RD_LAT,
    parameter int DATA_WIDTH = DRAM_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  oob_i,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  oob_o
);

    logic [RD_LAT-1:0]     valid_q;
    logic [RD_LAT-1:0]     oob_q;
    logic [DATA_WIDTH-1:0] data_q [RD_LAT];

    // Reset empties every stage so in-flight reads never resurface.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            oob_q   <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q[0] <= valid_i;
            oob_q[0]   <= oob_i;
            data_q[0]  <= data_i;
            for (int i = 1; i < RD_LAT; i++) begin
                valid_q[i] <= valid_q[i-1];
                oob_q[i]   <= oob_q[i-1];
                data_q[i]  <= data_q[i-1];
            end
        end
    end

    assign valid_o = valid_q[RD_LAT-1];
    assign oob_o   = oob_q[RD_LAT-1];
    assign data_o  = data_q[RD_LAT-1];

endmodule

// File: rtl/dram_resp.sv
// Behavioural DRAM responder: single-cycle writes, fully pipelined fixed-latency
// reads with write-first forwarding, out-of-range detection and a pending count.
module dram_resp
    import dram_pkg::*;
#(
    parameter int DATA_WIDTH = DRAM_DATA_WIDTH,
    parameter int ADDR_WIDTH = DRAM_ADDR_WIDTH,
    parameter int DEPTH      = DRAM_DEPTH,
    parameter int RD_LAT     = DRAM_RD_LAT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en_wr,
    input  logic [ADDR_WIDTH-1:0] addr_wr,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  en_rd,
    input  logic [ADDR_WIDTH-1:0] addr_rd,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  err_oob,
    output logic [PEND_WIDTH-1:0] pending
);

    localparam int          IDX_W     = idxWidth(DEPTH);
    localparam logic [32:0] DEPTH_EXT = 33'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  wrInRange;
    logic                  rdInRange;
    logic                  rdHit;
    logic [DATA_WIDTH-1:0] rdData;
    logic                  pipeValid;
    logic                  pipeOob;
    logic [DATA_WIDTH-1:0] pipeData;
    logic                  errOob_q;
    logic                  errOob_d;
    logic [PEND_WIDTH-1:0] pending_q;
    logic [PEND_WIDTH-1:0] pending_d;

    assign wrInRange = 33'(addr_wr) < DEPTH_EXT;
    assign rdInRange = 33'(addr_rd) < DEPTH_EXT;
    assign rdHit     = en_wr && wrInRange && (addr_wr == addr_rd);

    // A same-edge write to the read address wins, so forward data_in directly.
    always_comb begin
        rdData = '0;
        if (rdInRange) begin
            rdData = rdHit ? data_in : mem[addr_rd[IDX_W-1:0]];
        end
    end

    // Array has no reset: contents survive rst and start uninitialised.
    always_ff @(posedge clk) begin
        if (en_wr && wrInRange && !rst) begin
            mem[addr_wr[IDX_W-1:0]] <= data_in;
        end
    end

    dram_rd_pipe #(
        .RD_LAT    (RD_LAT),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_rd_pipe (
        .clk    (clk),
        .rst    (rst),
        .valid_i(en_rd),
        .data_i (rdData),
        .oob_i  (!rdInRange),
        .valid_o(pipeValid),
        .data_o (pipeData),
        .oob_o  (pipeOob)
    );

    always_comb begin
        errOob_d  = errOob_q | (en_wr && !wrInRange) | (en_rd && !rdInRange);
        pending_d = pending_q;
        unique case ({en_rd, pipeValid})
            2'b10:   pending_d = pending_q + 1'b1;
            2'b01:   pending_d = pending_q - 1'b1;
            default: pending_d = pending_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            errOob_q  <= 1'b0;
            pending_q <= '0;
        end else begin
            errOob_q  <= errOob_d;
            pending_q <= pending_d;
        end
    end

    assign valid    = pipeValid;
    assign data_out = (pipeValid && !pipeOob) ? pipeData : '0;
    assign err_oob  = errOob_q;
    assign pending  = pending_q;

endmodule

// File: tb/tb_dram_resp.sv
// Directed bench for dram_resp at read latencies 1, 2 and 8 sharing one stimulus
// stream, with a per-cycle reference scoreboard alongside hand-computed checks.
module tb_dram_resp;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en_wr = 1'b0;
    logic        en_rd = 1'b0;
    logic [17:0] addr_wr = '0;
    logic [17:0] addr_rd = '0;
    logic [31:0] data_in = '0;

    logic        valid1, valid2, valid8;
    logic [31:0] dout1, dout2, dout8;
    logic        err1, err2, err8;
    logic [3:0]  pend1, pend2, pend8;

    int testsRun = 0;
    int testsFailed = 0;

    always #5 clk = ~clk;

    dram_resp #(.RD_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .en_wr(en_wr), .addr_wr(addr_wr), .data_in(data_in),
        .en_rd(en_rd), .addr_rd(addr_rd), .valid(valid1), .data_out(dout1),
        .err_oob(err1), .pending(pend1)
    );

    dram_resp dut2 (
        .clk(clk), .rst(rst), .en_wr(en_wr), .addr_wr(addr_wr), .data_in(data_in),
        .en_rd(en_rd), .addr_rd(addr_rd), .valid(valid2), .data_out(dout2),
        .err_oob(err2), .pending(pend2)
    );

    dram_resp #(.RD_LAT(8)) dut8 (
        .clk(clk), .rst(rst), .en_wr(en_wr), .addr_wr(addr_wr), .data_in(data_in),
        .en_rd(en_rd), .addr_rd(addr_rd), .valid(valid8), .data_out(dout8),
        .err_oob(err8), .pending(pend8)
    );

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        testsRun++;
        if (obs !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One stimulus cycle: drive, let one rising edge sample it, then go idle.
    task automatic applyStimulus(input logic w, input logic [17:0] wa, input logic [31:0] wd,
                                 input logic r, input logic [17:0] ra);
        en_wr   = w;
        addr_wr = wa;
        data_in = wd;
        en_rd   = r;
        addr_rd = ra;
        @(posedge clk);
        #1;
        en_wr = 1'b0;
        en_rd = 1'b0;
    endtask

    function automatic logic obsValid(input int k);
        case (k)
            0:       return valid1;
            1:       return valid2;
            default: return valid8;
        endcase
    endfunction

    function automatic logic [31:0] obsData(input int k);
        case (k)
            0:       return dout1;
            1:       return dout2;
            default: return dout8;
        endcase
    endfunction

    function automatic logic [3:0] obsPend(input int k);
        case (k)
            0:       return pend1;
            1:       return pend2;
            default: return pend8;
        endcase
    endfunction

    function automatic logic obsErr(input int k);
        case (k)
            0:       return err1;
            1:       return err2;
            default: return err8;
        endcase
    endfunction

    // Reference model: request history indexed by edge number plus a shadow memory.
    int          latTab [3] = '{1, 2, 8};
    bit          reqV [0:8191];
    logic [31:0] reqD [0:8191];
    logic [31:0] refMem [0:4095];
    bit          errExp = 1'b0;
    int          cyc = 0;

    bit          capture = 1'b0;
    logic [31:0] cap [3][$];
    int          maxPend [3];
    int          firstV;
    int          lastV;

    always @(posedge clk) begin
        cyc = cyc + 1;
        reqV[cyc] = !rst && en_rd;
        reqD[cyc] = '0;
        if (!rst && en_rd) begin
            if (addr_rd >= 18'd4096) begin
                errExp = 1'b1;
            end else if (en_wr && addr_wr == addr_rd) begin
                reqD[cyc] = data_in;
            end else begin
                reqD[cyc] = refMem[addr_rd[11:0]];
            end
        end
        if (!rst && en_wr) begin
            if (addr_wr >= 18'd4096) errExp = 1'b1;
            else refMem[addr_wr[11:0]] = data_in;
        end
    end

    always @(negedge clk) begin
        int   l;
        int   j;
        int   ep;
        bit   ev;
        logic [31:0] ed;
        if (rst) begin
            for (int i = 0; i <= 8; i++) begin
                if (cyc - i >= 0) reqV[cyc-i] = 1'b0;
            end
            errExp = 1'b0;
        end
        for (int k = 0; k < 3; k++) begin
            l  = latTab[k];
            j  = cyc - l + 1;
            ev = (j >= 0) ? reqV[j] : 1'b0;
            ed = ev ? reqD[j] : 32'd0;
            ep = 0;
            for (int i = 0; i < l; i++) begin
                if (cyc - i >= 0 && reqV[cyc-i]) ep++;
            end
            checkOutput($sformatf("sb_L%0d_valid", l), obsValid(k), ev);
            checkOutput($sformatf("sb_L%0d_data", l), obsData(k), ed);
            checkOutput($sformatf("sb_L%0d_pending", l), obsPend(k), ep);
            checkOutput($sformatf("sb_L%0d_err", l), obsErr(k), errExp);
            if (capture) begin
                if (obsValid(k)) cap[k].push_back(obsData(k));
                if (int'(obsPend(k)) > maxPend[k]) maxPend[k] = int'(obsPend(k));
            end
        end
        if (capture && valid2) begin
            if (firstV < 0) firstV = cyc;
            lastV = cyc;
        end
    end

    initial begin
        int n;
        int cnt;

        // Reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("rst_valid", valid2, 1'b0);
        checkOutput("rst_data", dout2, 32'd0);
        checkOutput("rst_pending", pend2, 4'd0);
        checkOutput("rst_err", err2, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Single write then read, latency and pending per instance
        applyStimulus(1'b1, 18'd5, 32'hDEADBEEF, 1'b0, 18'd0);
        applyStimulus(1'b0, 18'd0, 32'd0, 1'b1, 18'd5);
        @(negedge clk);
        checkOutput("l2_t0_valid", valid2, 1'b0);
        checkOutput("l2_t0_pending", pend2, 4'd1);
        checkOutput("l1_t0_valid", valid1, 1'b1);
        checkOutput("l1_t0_data", dout1, 32'hDEADBEEF);
        checkOutput("l1_t0_pending", pend1, 4'd1);
        @(negedge clk);
        checkOutput("l2_t1_valid", valid2, 1'b1);
        checkOutput("l2_t1_data", dout2, 32'hDEADBEEF);
        checkOutput("l2_t1_pending", pend2, 4'd1);
        checkOutput("l1_t1_valid", valid1, 1'b0);
        checkOutput("l1_t1_pending", pend1, 4'd0);
        @(negedge clk);
        checkOutput("l2_t2_valid", valid2, 1'b0);
        checkOutput("l2_t2_pending", pend2, 4'd0);
        n = 2;
        while (!valid8 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("l8_latency", n, 7);
        checkOutput("l8_data", dout8, 32'hDEADBEEF);
        checkOutput("l8_pending", pend8, 4'd1);
        repeat (3) @(negedge clk);

        // Fill 0..15, then 16 back-to-back reads
        for (int k = 0; k < 16; k++) applyStimulus(1'b1, 18'(k), 32'(k), 1'b0, 18'd0);
        for (int k = 0; k < 3; k++) begin
            cap[k].delete();
            maxPend[k] = 0;
        end
        firstV  = -1;
        lastV   = -1;
        capture = 1'b1;
        for (int k = 0; k < 16; k++) applyStimulus(1'b0, 18'd0, 32'd0, 1'b1, 18'(k));
        repeat (12) @(negedge clk);
        capture = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("burst_L%0d_count", latTab[k]), cap[k].size(), 16);
            checkOutput($sformatf("burst_L%0d_peak", latTab[k]), maxPend[k], latTab[k]);
            for (int i = 0; i < cap[k].size() && i < 16; i++) begin
                checkOutput($sformatf("burst_L%0d_data%0d", latTab[k], i), cap[k][i], 32'(i));
            end
        end
        checkOutput("burst_L2_span", lastV - firstV, 15);

        // Same-edge write and read: write-first
        applyStimulus(1'b1, 18'd9, 32'h12345678, 1'b1, 18'd9);
        @(negedge clk);
        @(negedge clk);
        checkOutput("wf_valid", valid2, 1'b1);
        checkOutput("wf_data", dout2, 32'h12345678);

        // Out-of-range read and write
        applyStimulus(1'b1, 18'd0, 32'hA5A5A5A5, 1'b0, 18'd0);
        applyStimulus(1'b1, 18'd904, 32'h11111111, 1'b0, 18'd0);
        @(negedge clk);
        checkOutput("oob_err_before", err2, 1'b0);
        applyStimulus(1'b0, 18'd0, 32'd0, 1'b1, 18'd4096);
        @(negedge clk);
        @(negedge clk);
        checkOutput("oob_rd_valid", valid2, 1'b1);
        checkOutput("oob_rd_data", dout2, 32'd0);
        checkOutput("oob_rd_err", err2, 1'b1);
        repeat (4) @(negedge clk);
        checkOutput("oob_sticky_L1", err1, 1'b1);
        checkOutput("oob_sticky_L8", err8, 1'b1);
        applyStimulus(1'b1, 18'd5000, 32'hBADBAD00, 1'b0, 18'd0);
        applyStimulus(1'b0, 18'd0, 32'd0, 1'b1, 18'd904);
        applyStimulus(1'b0, 18'd0, 32'd0, 1'b1, 18'd0);
        @(negedge clk);
        checkOutput("oob_wr_keep904", dout2, 32'h11111111);
        @(negedge clk);
        checkOutput("oob_wr_keep0", dout2, 32'hA5A5A5A5);
        checkOutput("oob_sticky_L2", err2, 1'b1);
        repeat (8) @(negedge clk);

        // Reset in the middle of two outstanding reads
        applyStimulus(1'b0, 18'd0, 32'd0, 1'b1, 18'd5);
        applyStimulus(1'b0, 18'd0, 32'd0, 1'b1, 18'd9);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        cnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (valid1 || valid2 || valid8) cnt++;
        end
        checkOutput("rstmid_no_valid", cnt, 0);
        checkOutput("rstmid_pending_L2", pend2, 4'd0);
        checkOutput("rstmid_pending_L8", pend8, 4'd0);
        checkOutput("rstmid_err", err2, 1'b0);
        applyStimulus(1'b0, 18'd0, 32'd0, 1'b1, 18'd5);
        applyStimulus(1'b0, 18'd0, 32'd0, 1'b1, 18'd9);
        @(negedge clk);
        checkOutput("rstmid_keep5", dout2, 32'd5);
        @(negedge clk);
        checkOutput("rstmid_keep9", dout2, 32'h12345678);
        repeat (10) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
